ram_port_arbiter: RTL and testbench

//  Two-requester arbiter for the single-port 32x16 unified RAM. It replaces the static

---
 rtl/ram_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-port req/gnt arbiter in front of a single-port synchronous RAM, with lock/MAX_HOLD ownership.
// Optional macro ARB_ROUND_ROBIN_EN selects a round-robin base policy; otherwise port 0 has fixed priority.
module ram_port_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  logic [1:0]        req;
  logic              grant_any;
  logic              winner;
  logic              base_pick;
  logic              sel_we;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              owner_valid_reg, owner_valid_next;
  logic              owner_reg, owner_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;

  logic              acc_reg;
  logic              busy_reg;
  logic              ram_we_reg;
  logic [ADDR_W-1:0] ram_addr_reg;
  logic [DATA_W-1:0] ram_wdata_reg;
  logic              rd_pend_reg;
  logic              rd_port_reg;
  logic              rvalid0_reg;
  logic              rvalid1_reg;

  assign req = {req1, req0};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_reg;
  assign base_pick = ~last_reg;
  always_ff @(posedge clock) begin
    if (reset) begin
      last_reg <= 1'b1;
    end else if (grant_any) begin
      last_reg <= winner;
    end
  end
`else
  assign base_pick = 1'b0;
`endif

  // Owner keeps the port until MAX_HOLD grants have been used while the other side waits.
  always_comb begin
    grant_any = 1'b0;
    winner    = 1'b0;
    if (!reset && (req0 || req1)) begin
      grant_any = 1'b1;
      if (owner_valid_reg && req[owner_reg] && (hold_cnt_reg < HOLD_MAX)) begin
        winner = owner_reg;
      end else if (owner_valid_reg && (hold_cnt_reg == HOLD_MAX) && req[~owner_reg]) begin
        winner = ~owner_reg;
      end else if (req0 && req1) begin
        winner = base_pick;
      end else begin
        winner = req1;
      end
    end
  end

  assign gnt0      = grant_any & ~winner;
  assign gnt1      = grant_any & winner;
  assign sel_we    = winner ? we1    : we0;
  assign sel_lock  = winner ? lock1  : lock0;
  assign sel_addr  = winner ? addr1  : addr0;
  assign sel_wdata = winner ? wdata1 : wdata0;

  always_comb begin
    owner_valid_next = owner_valid_reg;
    owner_next       = owner_reg;
    hold_cnt_next    = hold_cnt_reg;
    if (grant_any) begin
      if (sel_lock) begin
        owner_valid_next = 1'b1;
        owner_next       = winner;
        if (owner_valid_reg && (owner_reg == winner)) begin
          hold_cnt_next = (hold_cnt_reg == HOLD_MAX) ? hold_cnt_reg : hold_cnt_reg + HOLD_ONE;
        end else begin
          hold_cnt_next = HOLD_ONE;
        end
      end else begin
        owner_valid_next = 1'b0;
        hold_cnt_next    = '0;
      end
    end else if (owner_valid_reg && !req[owner_reg]) begin
      owner_valid_next = 1'b0;
      hold_cnt_next    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_valid_reg <= 1'b0;
      owner_reg       <= 1'b0;
      hold_cnt_reg    <= '0;
      acc_reg         <= 1'b0;
      busy_reg        <= 1'b0;
      ram_we_reg      <= 1'b0;
      ram_addr_reg    <= '0;
      ram_wdata_reg   <= '0;
      rd_pend_reg     <= 1'b0;
      rd_port_reg     <= 1'b0;
      rvalid0_reg     <= 1'b0;
      rvalid1_reg     <= 1'b0;
    end else begin
      owner_valid_reg <= owner_valid_next;
      owner_reg       <= owner_next;
      hold_cnt_reg    <= hold_cnt_next;
      acc_reg         <= grant_any;
      busy_reg        <= grant_any | acc_reg;
      ram_we_reg      <= grant_any & sel_we;
      if (grant_any) begin
        ram_addr_reg  <= sel_addr;
        ram_wdata_reg <= sel_wdata;
      end
      rd_pend_reg     <= grant_any & ~sel_we;
      rd_port_reg     <= winner;
      rvalid0_reg     <= rd_pend_reg & ~rd_port_reg;
      rvalid1_reg     <= rd_pend_reg & rd_port_reg;
    end
  end

  assign ram_we    = ram_we_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_wdata = ram_wdata_reg;
  assign rvalid0   = rvalid0_reg;
  assign rvalid1   = rvalid1_reg;
  assign busy      = busy_reg;
  // The RAM's output register supplies the N+2 stage; data is zeroed outside its valid pulse.
  assign rdata     = (rvalid0_reg | rvalid1_reg) ? ram_rdata : '0;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model with a shadow copy of the RAM.
module tb_ram_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 16;
  localparam int MH = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_we, busy;
  logic [DW-1:0] rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] ram_mem [32];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy)
  );

  // Synchronous-read RAM; the preload port is only used while reset is held.
  always @(posedge clock) begin
    if (pre_en) ram_mem[pre_addr] <= pre_data;
    else if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  // Reference model state
  int            m_owner, m_streak, m_last;
  logic [DW-1:0] shadow [32];
  bit            s1_v, s1_we, s2_v, s2_we;
  int            s1_port, s2_port;
  logic [DW-1:0] s1_rd, s2_rd;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;

  int            obs_gnt;
  bit            obs_rv1, obs_we;
  logic [DW-1:0] obs_rdata;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    s1_v = 0; s2_v = 0; s1_we = 0; s2_we = 0; s1_port = 0; s2_port = 0;
    m_owner = -1; m_streak = 0; m_last = 1;
    e_addr = '0; e_wd = '0;
  endtask

  function automatic int pick();
    bit r [2];
    r[0] = req0; r[1] = req1;
    if (reset || (!req0 && !req1)) return -1;
    if (m_owner >= 0 && r[m_owner] && m_streak < MH) return m_owner;
    if (m_owner >= 0 && m_streak >= MH && r[1 - m_owner]) return 1 - m_owner;
    if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
      return 1 - m_last;
`else
      return 0;
`endif
    end
    return req1 ? 1 : 0;
  endfunction

  task automatic commit(int w);
    bit            r [2];
    bit            lk;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (reset) begin
      model_reset();
      return;
    end
    r[0] = req0; r[1] = req1;
    s2_v = s1_v; s2_we = s1_we; s2_port = s1_port; s2_rd = s1_rd;
    s1_v = (w >= 0);
    if (w >= 0) begin
      s1_port = w;
      s1_we   = (w == 1) ? we1 : we0;
      lk      = (w == 1) ? lock1 : lock0;
      a       = (w == 1) ? addr1 : addr0;
      d       = (w == 1) ? wdata1 : wdata0;
      if (s1_we) shadow[a] = d;
      s1_rd  = shadow[a];
      e_addr = a;
      e_wd   = d;
      if (!lk) begin
        m_owner = -1; m_streak = 0;
      end else begin
        m_streak = (m_owner == w) ? ((m_streak < MH) ? m_streak + 1 : MH) : 1;
        m_owner  = w;
      end
      m_last = w;
    end else if (m_owner >= 0 && !r[m_owner]) begin
      m_owner = -1; m_streak = 0;
    end
  endtask

  // One clock cycle: check all outputs against the model at the falling edge, then advance.
  task automatic tick();
    int w;
    bit rd_exp;
    @(negedge clock);
    w = pick();
    rd_exp = s2_v && !s2_we;
    chk("gnt0", 32'(gnt0), 32'(w == 0));
    chk("gnt1", 32'(gnt1), 32'(w == 1));
    chk("ram_we", 32'(ram_we), 32'(s1_v && s1_we));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("ram_wdata", 32'(ram_wdata), 32'(e_wd));
    chk("rvalid0", 32'(rvalid0), 32'(rd_exp && s2_port == 0));
    chk("rvalid1", 32'(rvalid1), 32'(rd_exp && s2_port == 1));
    chk("busy", 32'(busy), 32'(s1_v || s2_v));
    if (rd_exp) chk("rdata", 32'(rdata), 32'(s2_rd));
    else if (reset) chk("rst_rdata", 32'(rdata), 32'(0));
    obs_gnt   = gnt1 ? 1 : (gnt0 ? 0 : -1);
    obs_rv1   = rvalid1;
    obs_we    = ram_we;
    obs_rdata = rdata;
    @(posedge clock);
    commit(w);
    #1;
  endtask

  task automatic set_port(int p, int r, int we, int lk, int a, int d);
    if (p == 0) begin
      req0 = (r != 0); we0 = (we != 0); lock0 = (lk != 0); addr0 = AW'(a); wdata0 = DW'(d);
    end else begin
      req1 = (r != 0); we1 = (we != 0); lock1 = (lk != 0); addr1 = AW'(a); wdata1 = DW'(d);
    end
  endtask

  task automatic idle(int n);
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reset_pulse();
    req0 = 0; req1 = 0;
    reset = 1; tick(); reset = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            seq [10];
    bit            rv [7];
    logic [DW-1:0] rd [7];
    bit            pend [2];
    logic [DW-1:0] v;

    set_port(0, 0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0, 0);
    pre_en = 0; pre_addr = '0; pre_data = '0;
    reset = 1;
    // Preload RAM and shadow; addresses 0..3 carry the known pattern 0x0011..0x0044.
    for (int i = 0; i < 32; i++) begin
      v = (i < 4) ? DW'((i + 1) * 16'h0011) : DW'($urandom);
      pre_en = 1; pre_addr = AW'(i); pre_data = v; shadow[i] = v;
      @(posedge clock); #1;
    end
    pre_en = 0;
    model_reset();

    // 1: reset held with random inputs, then first request granted immediately
    for (int i = 0; i < 3; i++) begin
      set_port(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31), $urandom);
      set_port(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31), $urandom);
      tick();
    end
    reset = 0;
    set_port(0, 0, 0, 0, 0, 0);
    set_port(1, 1, 0, 0, 7, 0);
    tick();
    chk("t1_first_gnt", 32'(obs_gnt), 32'(1));
    idle(3);

    // 2: write 0xBEEF to addr 5 then read it back on port 1
    set_port(1, 1, 1, 0, 5, 16'hBEEF);
    tick();
    chk("t2_wr_gnt", 32'(obs_gnt), 32'(1));
    set_port(1, 1, 0, 0, 5, 0);
    tick();
    chk("t2_rd_gnt", 32'(obs_gnt), 32'(1));
    req1 = 0;
    tick();
    chk("t2_rv_early", 32'(obs_rv1), 32'(0));
    tick();
    chk("t2_rv", 32'(obs_rv1), 32'(1));
    chk("t2_rdata", 32'(obs_rdata), 32'(16'hBEEF));
    idle(2);

    // 3: both ports request continuously without lock
    reset_pulse();
    set_port(0, 1, 0, 0, 1, 0);
    set_port(1, 1, 0, 0, 2, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      seq[i] = obs_gnt;
    end
    for (int i = 0; i < 8; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      chk($sformatf("t3_gnt%0d", i), 32'(seq[i]), 32'(i % 2));
`else
      chk($sformatf("t3_gnt%0d", i), 32'(seq[i]), 32'(0));
`endif
    end
    idle(3);

    // 4: port 0 locks while port 1 waits: MAX_HOLD grants, then one to port 1
    reset_pulse();
    set_port(0, 1, 0, 1, 3, 0);
    set_port(1, 1, 0, 0, 4, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      seq[i] = obs_gnt;
    end
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t4_gnt%0d", i), 32'(seq[i]), 32'((i == MH) ? 1 : 0));
    end
    idle(3);

    // 5: back-to-back reads of addresses 0..3
    for (int i = 0; i < 7; i++) begin
      if (i < 4) set_port(1, 1, 0, 0, i, 0);
      else req1 = 0;
      tick();
      rv[i] = obs_rv1;
      rd[i] = obs_rdata;
    end
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("t5_rv%0d", i), 32'(rv[i]), 32'(i >= 2 && i <= 5));
      if (i >= 2 && i <= 5) chk($sformatf("t5_rd%0d", i), 32'(rd[i]), 32'((i - 1) * 16'h0011));
    end
    idle(2);

    // 6: reset the cycle after a read grant discards the read
    set_port(1, 1, 0, 0, 9, 0);
    tick();
    chk("t6_gnt", 32'(obs_gnt), 32'(1));
    req1 = 0;
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t6_no_rv%0d", i), 32'(obs_rv1), 32'(0));
      chk($sformatf("t6_no_we%0d", i), 32'(obs_we), 32'(0));
    end
    set_port(1, 1, 0, 0, 9, 0);
    tick();
    req1 = 0;
    tick();
    tick();
    chk("t6_rv_after", 32'(obs_rv1), 32'(1));
    chk("t6_rd_after", 32'(obs_rdata), 32'(shadow[9]));

    // Random traffic: requesters hold each transaction until granted
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if ($urandom_range(0, 3) != 0) begin
            set_port(p, 1, $urandom_range(0, 1), ($urandom_range(0, 9) < 7) ? 1 : 0,
                     $urandom_range(0, 7), $urandom);
            pend[p] = 1;
          end else if (p == 0) begin
            req0 = 0;
          end else begin
            req1 = 0;
          end
        end
      end
      reset = ($urandom_range(0, 99) == 0);
      tick();
      if (obs_gnt >= 0) pend[obs_gnt] = 0;
    end
    reset = 0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
